// File: rtl/sum_every_n_pkg.sv
// Shared types and helpers for the sum_every_n grouping accumulator.
// Imported by the top level and by the per-lane accumulator.
package sum_every_n_pkg;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    // A request of 0, or anything above the maximum, falls back to the maximum.
    function automatic int clamp_n(input int n_req, input int nmax);
        return ((n_req == 0) || (n_req > nmax)) ? nmax : n_req;
    endfunction

    // Wide enough that a full group of maximum-valued samples cannot overflow.
    function automatic int out_width(input int dw, input int nmax);
        return dw + $clog2(nmax);
    endfunction

endpackage

// File: rtl/sum_every_n_lane.sv
// One lane's accumulator: loads on the first beat of a group, then sums or
// keeps the unsigned maximum. acc_next already includes the current beat.
module sum_every_n_lane
    import sum_every_n_pkg::*;
#(
    parameter int DW = 8,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          beat,
    input  mode_e         mode,
    input  logic [DW-1:0] din,
    output logic [OW-1:0] acc_next
);

    logic [OW-1:0] acc_reg;
    logic [OW-1:0] din_ext;

    assign din_ext = OW'(din);

    always_comb begin
        acc_next = acc_reg;
        if (beat) begin
            if (start) begin
                acc_next = din_ext;
            end else if (mode == MODE_MAX) begin
                acc_next = (din_ext > acc_reg) ? din_ext : acc_reg;
            end else begin
                acc_next = acc_reg + din_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/sum_every_n.sv
// Groups valid beats into runs of a runtime length across NCH lanes and emits
// one sum or maximum per lane at each group end; flush emits partial groups.
module sum_every_n
    import sum_every_n_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NCH  = 1,
    parameter int NMAX = 3,
    parameter int CW   = $clog2(NMAX + 1),
    parameter int OW   = out_width(DW, NMAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     i_n,
    input  logic              i_mode,
    input  logic              i_flush,
    input  logic              i_dval,
    input  logic [NCH*DW-1:0] i,
    output logic              o_dval,
    output logic [NCH*OW-1:0] o,
    output logic [CW-1:0]     o_cnt,
    output logic              o_partial
);

    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [CW-1:0]     n_lat_reg, n_lat_next;
    mode_e             mode_lat_reg, mode_lat_next;

    logic              o_dval_reg, o_dval_next;
    logic [NCH*OW-1:0] o_reg, o_next;
    logic [CW-1:0]     o_cnt_reg, o_cnt_next;
    logic              o_partial_reg, o_partial_next;

    logic              start;
    mode_e             beat_mode;
    logic [CW-1:0]     n_eff;
    logic [CW-1:0]     n_cur;
    logic [CW-1:0]     cnt_inc;
    logic              closing;
    logic              emit;
    logic [NCH*OW-1:0] acc_next_all;

    // The first beat of a group uses the live request; later beats use the latch.
    assign start     = (cnt_reg == '0);
    assign n_eff     = CW'(clamp_n(int'(i_n), NMAX));
    assign n_cur     = start ? n_eff : n_lat_reg;
    assign beat_mode = start ? mode_e'(i_mode) : mode_lat_reg;
    assign cnt_inc   = cnt_reg + CW'(1);
    assign closing   = i_dval && (cnt_inc == n_cur);
    assign emit      = closing || (i_flush && (i_dval || !start));

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            sum_every_n_lane #(
                .DW(DW),
                .OW(OW)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .start   (start),
                .beat    (i_dval),
                .mode    (beat_mode),
                .din     (i[gi*DW +: DW]),
                .acc_next(acc_next_all[gi*OW +: OW])
            );
        end
    endgenerate

    always_comb begin
        cnt_next      = cnt_reg;
        n_lat_next    = n_lat_reg;
        mode_lat_next = mode_lat_reg;
        if (i_dval) begin
            cnt_next = cnt_inc;
            if (start) begin
                n_lat_next    = n_eff;
                mode_lat_next = mode_e'(i_mode);
            end
        end
        if (emit) begin
            cnt_next = '0;
        end
    end

    // Result fields hold between pulses; only the valid strobe drops.
    always_comb begin
        o_dval_next    = emit;
        o_next         = o_reg;
        o_cnt_next     = o_cnt_reg;
        o_partial_next = o_partial_reg;
        if (emit) begin
            o_next         = acc_next_all;
            o_cnt_next     = i_dval ? cnt_inc : cnt_reg;
            o_partial_next = !closing;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            n_lat_reg     <= '0;
            mode_lat_reg  <= MODE_SUM;
            o_dval_reg    <= 1'b0;
            o_reg         <= '0;
            o_cnt_reg     <= '0;
            o_partial_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            n_lat_reg     <= n_lat_next;
            mode_lat_reg  <= mode_lat_next;
            o_dval_reg    <= o_dval_next;
            o_reg         <= o_next;
            o_cnt_reg     <= o_cnt_next;
            o_partial_reg <= o_partial_next;
        end
    end

    assign o_dval    = o_dval_reg;
    assign o         = o_reg;
    assign o_cnt     = o_cnt_reg;
    assign o_partial = o_partial_reg;

endmodule

// File: tb/tb_sum_every_n.sv
// Bench for sum_every_n: two instances (NMAX=3/NCH=1 and NMAX=4/NCH=2) share
// stimulus; a group-level model is compared every cycle plus literal pins.
module tb_sum_every_n;

    logic        clk;
    logic        rst;
    logic [2:0]  i_n;
    logic        i_mode;
    logic        i_flush;
    logic        i_dval;
    logic [7:0]  lane0;
    logic [7:0]  lane1;

    logic        o_dval_a, o_dval_b;
    logic [9:0]  o_a;
    logic [19:0] o_b;
    logic [1:0]  o_cnt_a;
    logic [2:0]  o_cnt_b;
    logic        o_partial_a, o_partial_b;

    int checks = 0;
    int errors = 0;

    sum_every_n #(.DW(8), .NCH(1), .NMAX(3)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .i_n      (i_n[1:0]),
        .i_mode   (i_mode),
        .i_flush  (i_flush),
        .i_dval   (i_dval),
        .i        (lane0),
        .o_dval   (o_dval_a),
        .o        (o_a),
        .o_cnt    (o_cnt_a),
        .o_partial(o_partial_a)
    );

    sum_every_n #(.DW(8), .NCH(2), .NMAX(4)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .i_n      (i_n),
        .i_mode   (i_mode),
        .i_flush  (i_flush),
        .i_dval   (i_dval),
        .i        ({lane1, lane0}),
        .o_dval   (o_dval_b),
        .o        (o_b),
        .o_cnt    (o_cnt_b),
        .o_partial(o_partial_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: remembers the beats of the open group and reduces them when it closes.
    int     grp    [2][4][2];
    int     m_cnt  [2];
    int     m_len  [2];
    bit     m_mode [2];
    bit     e_dval [2];
    longint e_o    [2][2];
    int     e_cnt  [2];
    bit     e_part [2];

    function automatic int nmax_of(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic int nch_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_cnt[d]  <= 0;
                m_len[d]  <= 0;
                m_mode[d] <= 1'b0;
                e_dval[d] <= 1'b0;
                e_cnt[d]  <= 0;
                e_part[d] <= 1'b0;
                for (int l = 0; l < 2; l++) e_o[d][l] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic int c    = m_cnt[d];
                automatic int n    = m_len[d];
                automatic bit md   = m_mode[d];
                automatic int req  = 0;
                automatic int cnew = 0;
                automatic int res  = 0;
                automatic int cur  = 0;
                e_dval[d] <= 1'b0;
                if (i_dval && c == 0) begin
                    req = (d == 0) ? int'(i_n[1:0]) : int'(i_n);
                    n   = (req == 0 || req > nmax_of(d)) ? nmax_of(d) : req;
                    md  = i_mode;
                end
                if (i_dval) begin
                    grp[d][c][0] <= int'(lane0);
                    grp[d][c][1] <= int'(lane1);
                end
                cnew = c + (i_dval ? 1 : 0);
                if (cnew > 0 && (cnew == n || i_flush)) begin
                    for (int l = 0; l < nch_of(d); l++) begin
                        res = 0;
                        for (int b = 0; b < cnew; b++) begin
                            if (b == c) cur = (l == 0) ? int'(lane0) : int'(lane1);
                            else        cur = grp[d][b][l];
                            if (md) res = (cur > res) ? cur : res;
                            else    res = res + cur;
                        end
                        e_o[d][l] <= res;
                    end
                    e_dval[d] <= 1'b1;
                    e_cnt[d]  <= cnew;
                    e_part[d] <= (cnew != n);
                    m_cnt[d]  <= 0;
                end else begin
                    m_cnt[d] <= cnew;
                end
                m_len[d]  <= n;
                m_mode[d] <= md;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("a_dval", o_dval_a, e_dval[0]);
            chk("a_o", o_a, e_o[0][0]);
            chk("a_cnt", o_cnt_a, e_cnt[0]);
            chk("a_partial", o_partial_a, e_part[0]);
            chk("b_dval", o_dval_b, e_dval[1]);
            chk("b_o0", o_b[9:0], e_o[1][0]);
            chk("b_o1", o_b[19:10], e_o[1][1]);
            chk("b_cnt", o_cnt_b, e_cnt[1]);
            chk("b_partial", o_partial_b, e_part[1]);
        end
    end

    task automatic step(input bit v, input int a0, input int a1, input bit f);
        i_dval  = v;
        lane0   = 8'(a0);
        lane1   = 8'(a1);
        i_flush = f;
        @(posedge clk);
        #1;
        $display("beat v=%0d l0=%0d l1=%0d flush=%0d n=%0d mode=%0d -> a:%0d/%0d b:%0d/%0d,%0d",
                 v, a0, a1, f, i_n, i_mode, o_dval_a, o_a, o_dval_b, o_b[9:0], o_b[19:10]);
        i_dval  = 1'b0;
        i_flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; i_n = 3'd0; i_mode = 1'b0; i_flush = 1'b0; i_dval = 1'b0;
        lane0 = 8'd0; lane1 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_dval", o_dval_a, 0);
        chk("rst_b_o", o_b, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);

        // Default length, back-to-back groups
        i_n = 3'd0; i_mode = 1'b0;
        step(1, 1, 10, 0); step(1, 2, 20, 0); step(1, 3, 30, 0);
        chk("t1_a_dval", o_dval_a, 1);
        chk("t1_a_o", o_a, 6);
        chk("t1_a_cnt", o_cnt_a, 3);
        step(1, 4, 40, 0);
        chk("t1_b_o0", o_b[9:0], 10);
        chk("t1_b_o1", o_b[19:10], 100);
        chk("t1_b_cnt", o_cnt_b, 4);
        step(1, 5, 50, 0); step(1, 6, 60, 0);
        chk("t1_a_o2", o_a, 15);
        step(0, 0, 0, 1);
        chk("t1_b_flush_o1", o_b[19:10], 110);
        chk("t1_b_flush_cnt", o_cnt_b, 2);
        chk("t1_b_flush_part", o_partial_b, 1);
        chk("t1_a_noflush", o_dval_a, 0);
        step(0, 0, 0, 0);

        // Full-scale sum does not overflow
        i_n = 3'd4;
        repeat (4) step(1, 255, 255, 0);
        chk("t2_b_o0", o_b[9:0], 1020);
        chk("t2_b_o1", o_b[19:10], 1020);
        step(0, 0, 0, 1);
        chk("t2_a_tail", o_a, 255);
        step(0, 0, 0, 0);

        // Max mode
        i_n = 3'd3; i_mode = 1'b1;
        step(1, 5, 200, 0); step(1, 9, 7, 0); step(1, 2, 201, 0);
        chk("t3_a_max", o_a, 9);
        chk("t3_b_max1", o_b[19:10], 201);
        i_mode = 1'b0;
        step(0, 0, 0, 0);

        // Idle flush of a partial group, then an empty flush
        step(1, 10, 1, 0); step(1, 20, 2, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t4_a_o", o_a, 30);
        chk("t4_a_cnt", o_cnt_a, 2);
        chk("t4_a_part", o_partial_a, 1);
        step(0, 0, 0, 1);
        chk("t4_empty_a", o_dval_a, 0);
        chk("t4_empty_b", o_dval_b, 0);

        // Flush coinciding with a beat, partial and closing
        step(1, 7, 0, 0); step(0, 0, 0, 0); step(1, 8, 0, 1);
        chk("t5_a_o", o_a, 15);
        chk("t5_a_part", o_partial_a, 1);
        i_n = 3'd2;
        step(1, 3, 0, 0); step(1, 4, 0, 1);
        chk("t5_close_o", o_a, 7);
        chk("t5_close_part", o_partial_a, 0);
        chk("t5_close_cnt", o_cnt_a, 2);

        // N=1 back-to-back
        i_n = 3'd1;
        step(1, 4, 0, 0); step(1, 5, 0, 0);
        chk("t6_dval", o_dval_a, 1);
        chk("t6_o", o_a, 5);
        step(1, 6, 0, 0);
        chk("t6_dval2", o_dval_a, 1);

        // Mid-group length change is ignored, then reset mid-group
        i_n = 3'd3;
        step(1, 1, 0, 0);
        i_n = 3'd1;
        step(1, 2, 0, 0);
        chk("t7_nochg", o_dval_a, 0);
        step(1, 3, 0, 0);
        chk("t7_o", o_a, 6);
        i_n = 3'd3;
        step(1, 100, 0, 0); step(1, 50, 0, 0);
        rst = 1'b0;
        #1;
        chk("t7_rst_dval", o_dval_a, 0);
        chk("t7_rst_o", o_a, 0);
        chk("t7_rst_cnt", o_cnt_a, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk("t7_after_o", o_a, 3);
        chk("t7_after_cnt", o_cnt_a, 3);
        repeat (3) step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
